// File: rtl/mult_issue_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mult_issue_arbiter
//  Purpose  : Shares one pipelined multiplier datapath between NUM_REQ
//             requesters. Picks requesters round-robin, registers their
//             operands into the datapath, and follows each requester ID
//             through the datapath latency with a tag shift register.
//             Products land in a credit-protected response FIFO. The
//             datapath cannot stall, so a product must never meet a full
//             FIFO.
//  Options  : MULT_ARB_QOS_EN - when defined, requester 0 has strict
//             priority over the round-robin among requesters 1..NUM_REQ-1.
//  Ports    : clk, rst (async, active-low)
//             req_valid/req_ready/req_a/req_b/req_unsigned - requester side
//             mul_valid/mul_a/mul_b/mul_unsigned -> datapath (registered)
//             mul_p <- datapath product, MUL_LAT cycles after mul_valid
//             rsp_valid/rsp_ready/rsp_id/rsp_p    - response side
//             idle - nothing issued, in flight or buffered
//  Revision : 1.0 - initial release
// ============================================================================
module mult_issue_arbiter #(
    parameter int W       = 16,
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*W-1:0]       req_a,
    input  logic [NUM_REQ*W-1:0]       req_b,
    input  logic [NUM_REQ-1:0]         req_unsigned,
    output logic                       mul_valid,
    output logic [W-1:0]               mul_a,
    output logic [W-1:0]               mul_b,
    output logic                       mul_unsigned,
    input  logic [2*W-1:0]             mul_p,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [2*W-1:0]             rsp_p,
    output logic                       idle
);

    localparam int DEPTH = MUL_LAT + 1;
    localparam int IDW   = $clog2(NUM_REQ);
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

`ifdef MULT_ARB_QOS_EN
    localparam bit QOS_EN = 1'b1;
`else
    localparam bit QOS_EN = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDW-1:0]   r_rr_ptr;
    logic [CW-1:0]    r_credits;
    logic             r_mul_valid;
    logic [W-1:0]     r_mul_a;
    logic [W-1:0]     r_mul_b;
    logic             r_mul_unsigned;
    logic [IDW-1:0]   r_issue_id;
    logic [MUL_LAT-1:0] r_tag_vld;
    logic [IDW-1:0]   r_tag_id [MUL_LAT];
    logic [IDW-1:0]   r_fifo_id [DEPTH];
    logic [2*W-1:0]   r_fifo_p  [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_grant_vld;
    logic [IDW-1:0]   w_grant_idx;
    logic [IDW:0]     w_scan;
    logic [W-1:0]     w_sel_a;
    logic [W-1:0]     w_sel_b;
    logic             w_sel_uns;
    logic             w_push;
    logic             w_pop;

    // ------------------------------------------------------------------
    // Arbitration: scan from r_rr_ptr upward with wrap. In QoS mode
    // requester 0 is decided up front and skipped by the scan.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_scan      = '0;
        if (r_credits != '0) begin
            if (QOS_EN && req_valid[0]) begin
                w_grant_vld = 1'b1;
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                w_scan = {1'b0, r_rr_ptr} + (IDW+1)'(k);
                if (w_scan >= (IDW+1)'(NUM_REQ)) begin
                    w_scan = w_scan - (IDW+1)'(NUM_REQ);
                end
                if (!w_grant_vld && req_valid[w_scan[IDW-1:0]] &&
                    !(QOS_EN && (w_scan == '0))) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = w_scan[IDW-1:0];
                end
            end
        end
    end

    // Operand mux for the granted requester
    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_uns = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant_idx == IDW'(k)) begin
                w_sel_a   = req_a[k*W +: W];
                w_sel_b   = req_b[k*W +: W];
                w_sel_uns = req_unsigned[k];
            end
        end
    end

    // Grants are masked while reset is held so nothing looks accepted
    always_comb begin
        req_ready = '0;
        if (w_grant_vld && rst) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Issue register and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mul_valid    <= 1'b0;
            r_mul_a        <= '0;
            r_mul_b        <= '0;
            r_mul_unsigned <= 1'b0;
            r_issue_id     <= '0;
            r_rr_ptr       <= '0;
        end else begin
            r_mul_valid <= w_grant_vld;
            if (w_grant_vld) begin
                r_mul_a        <= w_sel_a;
                r_mul_b        <= w_sel_b;
                r_mul_unsigned <= w_sel_uns;
                r_issue_id     <= w_grant_idx;
                // A strict-priority win by requester 0 leaves the rotation alone
                if (!(QOS_EN && (w_grant_idx == '0))) begin
                    r_rr_ptr <= (w_grant_idx == IDW'(NUM_REQ-1)) ? '0
                                                                 : w_grant_idx + 1'b1;
                end
            end
        end
    end

    assign mul_valid    = r_mul_valid;
    assign mul_a        = r_mul_a;
    assign mul_b        = r_mul_b;
    assign mul_unsigned = r_mul_unsigned;

    // ------------------------------------------------------------------
    // Tag pipe: fed from the issue register, so the last stage lines up
    // with mul_p exactly MUL_LAT cycles after the mul_valid cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_vld <= '0;
            for (int k = 0; k < MUL_LAT; k++) begin
                r_tag_id[k] <= '0;
            end
        end else begin
            r_tag_vld[0] <= r_mul_valid;
            r_tag_id[0]  <= r_issue_id;
            for (int k = 1; k < MUL_LAT; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_id[k]  <= r_tag_id[k-1];
            end
        end
    end

    assign w_push = r_tag_vld[MUL_LAT-1];
    assign w_pop  = rsp_valid & rsp_ready;

    // ------------------------------------------------------------------
    // Response FIFO. Storage needs no reset: outputs are gated by
    // occupancy, and the credit scheme guarantees room for every push.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_id[r_wr_ptr] <= r_tag_id[MUL_LAT-1];
            r_fifo_p[r_wr_ptr]  <= mul_p;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_credits <= CW'(DEPTH);
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A credit is held from issue until its response is popped
            case ({w_grant_vld, w_pop})
                2'b10:   r_credits <= r_credits - 1'b1;
                2'b01:   r_credits <= r_credits + 1'b1;
                default: r_credits <= r_credits;
            endcase
        end
    end

    assign rsp_valid = (r_count != '0);
    assign rsp_id    = rsp_valid ? r_fifo_id[r_rd_ptr] : '0;
    assign rsp_p     = rsp_valid ? r_fifo_p[r_rd_ptr]  : '0;
    assign idle      = !r_mul_valid && (r_tag_vld == '0) && !rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_mult_issue_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mult_issue_arbiter
//  Purpose  : Self-checking bench for mult_issue_arbiter (W=16, NUM_REQ=4,
//             MUL_LAT=2). A stand-in datapath multiplies the issued
//             operands; a transaction-level model predicts grants, credits
//             and the ordered response stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_issue_arbiter;

    localparam int W     = 16;
    localparam int NR    = 4;
    localparam int ML    = 2;
    localparam int DEPTH = ML + 1;
`ifdef MULT_ARB_QOS_EN
    localparam bit QOS = 1'b1;
`else
    localparam bit QOS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [NR*W-1:0] req_a = '0;
    logic [NR*W-1:0] req_b = '0;
    logic [NR-1:0]   req_unsigned = '0;
    logic            mul_valid;
    logic [W-1:0]    mul_a;
    logic [W-1:0]    mul_b;
    logic            mul_unsigned;
    logic [2*W-1:0]  mul_p;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [1:0]      rsp_id;
    logic [2*W-1:0]  rsp_p;
    logic            idle;

    mult_issue_arbiter #(.W(W), .NUM_REQ(NR), .MUL_LAT(ML)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_unsigned(req_unsigned),
        .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_unsigned(mul_unsigned), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_p(rsp_p), .idle(idle)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic u);
        logic [2*W-1:0] ea;
        logic [2*W-1:0] eb;
        ea = u ? {{W{1'b0}}, a} : {{W{a[W-1]}}, a};
        eb = u ? {{W{1'b0}}, b} : {{W{b[W-1]}}, b};
        return ea * eb;
    endfunction

    // Stand-in pipelined datapath: ML register stages
    logic [2*W-1:0] p_pipe [ML];
    always @(posedge clk) begin
        p_pipe[0] <= prod(mul_a, mul_b, mul_unsigned);
        for (int k = 1; k < ML; k++) p_pipe[k] <= p_pipe[k-1];
    end
    assign mul_p = p_pipe[ML-1];

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        int             id;
        logic [2*W-1:0] p;
        int             rdy;
    } exp_t;

    exp_t           m_q[$];
    int             m_credits = DEPTH;
    int             m_rr = 0;
    int             cyc = 0;
    int             exp_gnt;
    logic [NR-1:0]  exp_ready;
    logic           exp_rv;
    logic           exp_idle;
    logic [1:0]     exp_id;
    logic [2*W-1:0] exp_p;
    int             n_cmp = 0;
    int             n_fail = 0;

    function automatic void model_reset();
        m_q.delete();
        m_credits = DEPTH;
        m_rr      = 0;
    endfunction

    function automatic void eval_model();
        exp_gnt = -1;
        if (rst && m_credits > 0) begin
            if (QOS && req_valid[0]) exp_gnt = 0;
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_rr + k) % NR;
                if (exp_gnt < 0 && req_valid[i] && !(QOS && i == 0)) exp_gnt = i;
            end
        end
        exp_ready = '0;
        if (exp_gnt >= 0) exp_ready[exp_gnt] = 1'b1;
        exp_rv   = (m_q.size() > 0) && (m_q[0].rdy <= cyc);
        exp_id   = exp_rv ? 2'(m_q[0].id) : 2'd0;
        exp_p    = exp_rv ? m_q[0].p : '0;
        exp_idle = (m_q.size() == 0);
    endfunction

    function automatic logic [NR*W-1:0] rnd_ops();
        logic [NR*W-1:0] r;
        for (int k = 0; k < NR; k++) r[k*W +: W] = W'($urandom);
        return r;
    endfunction

    task automatic set_in(input logic [NR-1:0] v, input logic [NR*W-1:0] a,
                          input logic [NR*W-1:0] b, input logic [NR-1:0] u, input logic r);
        @(negedge clk);
        req_valid = v; req_a = a; req_b = b; req_unsigned = u; rsp_ready = r;
        #1;
        eval_model();
    endtask

    // Advance one clock and apply the handshakes predicted for this cycle
    task automatic tick();
        int   g;
        bit   pop;
        exp_t e;
        g   = exp_gnt;
        pop = exp_rv && rsp_ready;
        e   = '{id: 0, p: '0, rdy: 0};
        if (g >= 0) begin
            e.id  = g;
            e.p   = prod(req_a[g*W +: W], req_b[g*W +: W], req_unsigned[g]);
            e.rdy = cyc + ML + 2;
        end
        @(posedge clk);
        if (rst) begin
            if (pop) begin
                void'(m_q.pop_front());
                m_credits++;
            end
            if (g >= 0) begin
                m_q.push_back(e);
                m_credits--;
                if (!(QOS && g == 0)) m_rr = (g + 1) % NR;
            end
        end
        cyc++;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && !exp_idle; k++) begin
            set_in('0, '0, '0, '0, 1'b1);
            tick();
        end
        set_in('0, '0, '0, '0, 1'b1);
    endtask

    // --------------------------------- tests ---------------------------------
    task automatic test_reset();
        model_reset();
        set_in(4'hF, rnd_ops(), rnd_ops(), '0, 1'b1);
        n_cmp++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_cmp++; if (mul_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mul_valid: got %b want 0", mul_valid); end
        n_cmp++; if ({mul_a, mul_b, mul_unsigned} !== '0) begin n_fail++; $display("FAIL reset_mul_ops: got %h/%h/%b want 0", mul_a, mul_b, mul_unsigned); end
        n_cmp++; if ({rsp_valid, rsp_id, rsp_p} !== '0) begin n_fail++; $display("FAIL reset_rsp: got v=%b id=%0d p=%h want 0", rsp_valid, rsp_id, rsp_p); end
        n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
        tick();
        @(negedge clk);
        req_valid = '0; rst = 1'b1;
        #1; eval_model();
        tick();
    endtask

    task automatic test_round_robin();
        int nxt = 0;
        int pnxt = 0;
        for (int c = 0; c < 16; c++) begin
            set_in(4'hF, rnd_ops(), rnd_ops(), 4'($urandom), 1'b1);
            n_cmp++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rr_ready: got %b want %b", req_ready, exp_ready); end
            if (req_ready != '0) begin
                logic [NR-1:0] oh;
                oh = 4'b0001 << nxt;
                n_cmp++; if (req_ready !== oh) begin n_fail++; $display("FAIL rr_order: got %b want %b", req_ready, oh); end
                nxt = (nxt + 1) % NR;
            end
            if (rsp_valid) begin
                n_cmp++; if (rsp_id !== 2'(pnxt)) begin n_fail++; $display("FAIL rr_rsp_id: got %0d want %0d", rsp_id, pnxt); end
                n_cmp++; if (rsp_p !== exp_p) begin n_fail++; $display("FAIL rr_rsp_p: got %h want %h", rsp_p, exp_p); end
                pnxt = (pnxt + 1) % NR;
            end
            tick();
        end
        drain();
        n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rr_drain_idle: got %b want 1", idle); end
    endtask

    task automatic test_single();
        set_in(4'b0010, {NR{16'h0003}}, {NR{16'h0005}}, 4'b0010, 1'b1);
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL single_grant: got %b want 0010", req_ready); end
        tick();
        for (int k = 1; k <= 5; k++) begin
            set_in('0, '0, '0, '0, 1'b1);
            n_cmp++; if (rsp_valid !== (k == 4)) begin n_fail++; $display("FAIL single_latency: cycle %0d got %b want %b", k, rsp_valid, (k == 4)); end
            if (k == 4) begin
                n_cmp++; if (rsp_id !== 2'd1) begin n_fail++; $display("FAIL single_id: got %0d want 1", rsp_id); end
                n_cmp++; if (rsp_p !== 32'h0000000F) begin n_fail++; $display("FAIL single_p: got %h want 0000000f", rsp_p); end
            end
            tick();
        end
    endtask

    task automatic test_signed();
        logic [2*W-1:0] got[$];
        set_in(4'b0100, {NR{16'hFFFF}}, {NR{16'h0002}}, 4'b0000, 1'b1);
        tick();
        set_in(4'b0100, {NR{16'hFFFF}}, {NR{16'h0002}}, 4'b0100, 1'b1);
        tick();
        for (int k = 0; k < 8; k++) begin
            set_in('0, '0, '0, '0, 1'b1);
            if (rsp_valid) got.push_back(rsp_p);
            tick();
        end
        n_cmp++; if (got.size() != 2) begin n_fail++; $display("FAIL signed_count: got %0d want 2", got.size()); end
        else begin
            n_cmp++; if (got[0] !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL signed_p: got %h want fffffffe", got[0]); end
            n_cmp++; if (got[1] !== 32'h0001FFFE) begin n_fail++; $display("FAIL unsigned_p: got %h want 0001fffe", got[1]); end
        end
    endtask

    task automatic test_backpressure();
        int hs = 0;
        int issued[$];
        int popped[$];
        for (int c = 0; c < 10; c++) begin
            set_in(4'hF, rnd_ops(), rnd_ops(), 4'($urandom), 1'b0);
            n_cmp++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL bp_ready: got %b want %b", req_ready, exp_ready); end
            for (int i = 0; i < NR; i++) if (req_ready[i]) begin hs++; issued.push_back(i); end
            tick();
        end
        n_cmp++; if (hs != DEPTH) begin n_fail++; $display("FAIL bp_handshakes: got %0d want %0d", hs, DEPTH); end
        n_cmp++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL bp_stalled: got %b want 0000", req_ready); end
        for (int c = 0; c < 12; c++) begin
            set_in(4'hF, rnd_ops(), rnd_ops(), 4'($urandom), 1'b1);
            n_cmp++; if (rsp_valid !== exp_rv) begin n_fail++; $display("FAIL bp_rsp_valid: got %b want %b", rsp_valid, exp_rv); end
            n_cmp++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL bp_resume_ready: got %b want %b", req_ready, exp_ready); end
            if (rsp_valid) popped.push_back(int'(rsp_id));
            tick();
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (popped.size() <= i || popped[i] != issued[i]) begin
                n_fail++; $display("FAIL bp_order: slot %0d got %0d want %0d", i, (popped.size() > i) ? popped[i] : -1, issued[i]);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int hs = 0;
        set_in(4'b0010, rnd_ops(), rnd_ops(), 4'hF, 1'b1); tick();
        set_in(4'b0010, rnd_ops(), rnd_ops(), 4'hF, 1'b1); tick();
        set_in('0, '0, '0, '0, 1'b1); tick();
        @(negedge clk);
        rst = 1'b0; model_reset();
        #1; eval_model();
        n_cmp++; if ({rsp_valid, idle, mul_valid} !== 3'b010) begin n_fail++; $display("FAIL midrst_hold: got v=%b idle=%b mv=%b want 0/1/0", rsp_valid, idle, mul_valid); end
        tick();
        @(negedge clk);
        rst = 1'b1;
        #1; eval_model();
        tick();
        for (int c = 0; c < 6; c++) begin
            set_in('0, '0, '0, '0, 1'b1);
            n_cmp++; if ({rsp_valid, idle} !== 2'b01) begin n_fail++; $display("FAIL midrst_quiet: got v=%b idle=%b want 0/1", rsp_valid, idle); end
            tick();
        end
        for (int c = 0; c < 6; c++) begin
            set_in(4'hF, rnd_ops(), rnd_ops(), '0, 1'b0);
            if (c == 0) begin
                n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_first_grant: got %b want 0001", req_ready); end
            end
            for (int i = 0; i < NR; i++) if (req_ready[i]) hs++;
            tick();
        end
        n_cmp++; if (hs != DEPTH) begin n_fail++; $display("FAIL midrst_credits: got %0d want %0d", hs, DEPTH); end
        drain();
    endtask

    task automatic test_priority();
        logic [NR-1:0] want;
        set_in(4'b0001, rnd_ops(), rnd_ops(), '0, 1'b1);
        tick();
        set_in(4'b0101, rnd_ops(), rnd_ops(), '0, 1'b1);
        want = QOS ? 4'b0001 : 4'b0100;
        n_cmp++; if (req_ready !== want) begin n_fail++; $display("FAIL priority_grant: got %b want %b", req_ready, want); end
        tick();
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_in(4'($urandom), rnd_ops(), rnd_ops(), 4'($urandom), ($urandom_range(3) != 0));
            n_cmp++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready: cyc %0d got %b want %b", cyc, req_ready, exp_ready); end
            n_cmp++; if (rsp_valid !== exp_rv) begin n_fail++; $display("FAIL rand_rsp_valid: cyc %0d got %b want %b", cyc, rsp_valid, exp_rv); end
            n_cmp++; if ({rsp_id, rsp_p} !== {exp_id, exp_p}) begin n_fail++; $display("FAIL rand_rsp: cyc %0d got %0d/%h want %0d/%h", cyc, rsp_id, rsp_p, exp_id, exp_p); end
            n_cmp++; if (idle !== exp_idle) begin n_fail++; $display("FAIL rand_idle: cyc %0d got %b want %b", cyc, idle, exp_idle); end
            tick();
        end
        drain();
        n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rand_drain_idle: got %b want 1", idle); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_signed();
        test_backpressure();
        test_reset_mid();
        test_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
